sevseg_capture: RTL and testbench

- Receive side of the multiplexed 7-segment display bus: samples active-low anode and segment lines driven by a scanning display driver (internal loopback or a Pmod from a second Basys 3).
- Recovers one BCD digit per anode, with per-digit valid, blank and error flags.
- Used for on-board loopback self-test of the display path and for reading a remote board's display.
- Only samples once the lines have settled, and ages out digits that stop being refreshed.

---
 rtl/sevseg_pkg.sv | 29 ++
 rtl/sevseg_decode.sv | 29 ++
 rtl/sevseg_capture.sv | 187 ++++++++++++++++++
 tb/tb_sevseg_capture.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// Shared 7-segment definitions: active-low segment patterns (g..a), stored codes
// and the capture FSM state type. The display driver uses the same table.
package sevseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [9:0][6:0] SEG_TABLE = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
                                           SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HELD
  } cap_state_e;

endpackage

// File: rtl/sevseg_decode.sv
// Combinational reverse lookup from an active-low segment pattern to a BCD code,
// flagging the all-off pattern as blank and anything unrecognised as an error.
module sevseg_decode
  import sevseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       is_blank,
  output logic       is_err
);

  always_comb begin
    code     = CODE_ERR;
    is_blank = 1'b0;
    is_err   = 1'b1;
    if (seg == SEG_BLANK) begin
      code     = CODE_BLANK;
      is_blank = 1'b1;
      is_err   = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      if (seg == SEG_TABLE[i]) begin
        code   = 4'(i);
        is_err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sevseg_capture.sv
// Receive side of a multiplexed 7-segment bus: waits for anode and segments to
// settle, then captures one BCD digit per anode and ages out stale digits.
module sevseg_capture
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SETTLE_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 3200000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_DIGITS-1:0]         an_in,
  input  logic [6:0]                    seg_in,
  output logic [4*NUM_DIGITS-1:0]       bcd_out,
  output logic [NUM_DIGITS-1:0]         digit_valid,
  output logic [NUM_DIGITS-1:0]         digit_blank,
  output logic [NUM_DIGITS-1:0]         digit_err,
  output logic                          cap_strobe,
  output logic [$clog2(NUM_DIGITS)-1:0] cap_idx
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  logic [NUM_DIGITS-1:0]   an_s1_q, an_s1_d, an_s2_q, an_s2_d;
  logic [6:0]              seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
  cap_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [NUM_DIGITS-1:0]   lat_an_q, lat_an_d;
  logic [6:0]              lat_seg_q, lat_seg_d;
  logic [IDX_W-1:0]        lat_idx_q, lat_idx_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d, blank_q, blank_d, err_q, err_d;
  logic                    strobe_q, strobe_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  int                      zeros;
  logic [IDX_W-1:0]        an_idx;
  logic                    an_legal, changed, relatch, capture;
  logic [3:0]              dec_code;
  logic                    dec_blank, dec_err;

  // The latched segments equal the live ones on the capture cycle.
  sevseg_decode u_decode (
    .seg      (lat_seg_q),
    .code     (dec_code),
    .is_blank (dec_blank),
    .is_err   (dec_err)
  );

  always_comb begin
    an_s1_d  = an_in;
    an_s2_d  = an_s1_q;
    seg_s1_d = seg_in;
    seg_s2_d = seg_s1_q;

    zeros  = 0;
    an_idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!an_s2_q[k]) begin
        zeros  = zeros + 1;
        an_idx = IDX_W'(k);
      end
    end
    an_legal = (zeros == 1);
    changed  = (an_s2_q != lat_an_q) || (seg_s2_q != lat_seg_q);

    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_an_d  = lat_an_q;
    lat_seg_d = lat_seg_q;
    lat_idx_d = lat_idx_q;
    relatch   = 1'b0;
    capture   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (an_legal) relatch = 1'b1;
      end
      ST_SETTLE: begin
        if (!an_legal) begin
          state_d = ST_IDLE;
        end else if (changed) begin
          relatch = 1'b1;
        end else begin
          if (cnt_q != CNT_W'(SETTLE_CYCLES - 1)) cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(SETTLE_CYCLES - 2)) begin
            capture = 1'b1;
            state_d = ST_HELD;
          end
        end
      end
      ST_HELD: begin
        if (!an_legal) state_d = ST_IDLE;
        else if (changed) relatch = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (relatch) begin
      lat_an_d  = an_s2_q;
      lat_seg_d = seg_s2_q;
      lat_idx_d = an_idx;
      cnt_d     = '0;
      state_d   = ST_SETTLE;
    end

    bcd_d    = bcd_q;
    valid_d  = valid_q;
    blank_d  = blank_q;
    err_d    = err_q;
    seen_d   = seen_q;
    strobe_d = 1'b0;
    idx_d    = idx_q;

    // Aging clear is applied first so a capture in the wrap cycle survives it.
    if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      tmo_d   = '0;
      valid_d = valid_q & seen_q;
      seen_d  = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    if (capture) begin
      bcd_d[4*int'(lat_idx_q) +: 4] = dec_code;
      valid_d[lat_idx_q]            = 1'b1;
      seen_d[lat_idx_q]             = 1'b1;
      blank_d[lat_idx_q]            = dec_blank;
      err_d[lat_idx_q]              = dec_err;
      strobe_d                      = 1'b1;
      idx_d                         = lat_idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_s1_q  <= '1;
      an_s2_q  <= '1;
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      tmo_q    <= '0;
      seen_q   <= '0;
      bcd_q    <= '0;
      valid_q  <= '0;
      blank_q  <= '0;
      err_q    <= '0;
      strobe_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      an_s1_q  <= an_s1_d;
      an_s2_q  <= an_s2_d;
      seg_s1_q <= seg_s1_d;
      seg_s2_q <= seg_s2_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      seen_q   <= seen_d;
      bcd_q    <= bcd_d;
      valid_q  <= valid_d;
      blank_q  <= blank_d;
      err_q    <= err_d;
      strobe_q <= strobe_d;
      idx_q    <= idx_d;
    end
  end

  // Latched compare values are always rewritten before use, so they need no reset.
  always_ff @(posedge clk) begin
    lat_an_q  <= lat_an_d;
    lat_seg_q <= lat_seg_d;
    lat_idx_q <= lat_idx_d;
  end

  assign bcd_out     = bcd_q;
  assign digit_valid = valid_q;
  assign digit_blank = blank_q;
  assign digit_err   = err_q;
  assign cap_strobe  = strobe_q;
  assign cap_idx     = idx_q;

endmodule

// File: tb/tb_sevseg_capture.sv
// Bench for sevseg_capture: directed scenarios plus random scanning, checked every
// cycle against a run-length reference model of settle/capture/aging.
module tb_sevseg_capture;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 64;

  localparam logic [6:0] PAT [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                      7'b0110000, 7'b0011001, 7'b0010010,
                                      7'b0000010, 7'b1111000, 7'b0000000,
                                      7'b0010000};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an_in;
  logic [6:0]  seg_in;
  logic [15:0] bcd_out;
  logic [3:0]  digit_valid, digit_blank, digit_err;
  logic        cap_strobe;
  logic [1:0]  cap_idx;

  sevseg_capture #(
    .NUM_DIGITS     (4),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an_in       (an_in),
    .seg_in      (seg_in),
    .bcd_out     (bcd_out),
    .digit_valid (digit_valid),
    .digit_blank (digit_blank),
    .digit_err   (digit_err),
    .cap_strobe  (cap_strobe),
    .cap_idx     (cap_idx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int strobes = 0;
  int strobe_log[$];

  // Reference model state
  logic [10:0] m_d1, m_d2, m_prev;
  int          m_run;
  logic [15:0] m_bcd;
  logic [3:0]  m_valid, m_seen, m_blank, m_err;
  logic        m_strobe;
  logic [1:0]  m_idx;
  int          m_edge;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_code(input logic [6:0] s);
    if (s == 7'h7F) return 4'hF;
    for (int i = 0; i < 10; i++) if (s == PAT[i]) return 4'(i);
    return 4'hE;
  endfunction

  function automatic logic [3:0] an_sel(input int d);
    logic [3:0] a;
    a = 4'b1111;
    a[d] = 1'b0;
    return a;
  endfunction

  task automatic model_reset();
    m_d1 = '1; m_d2 = '1; m_prev = '1; m_run = 0;
    m_bcd = '0; m_valid = '0; m_seen = '0; m_blank = '0; m_err = '0;
    m_strobe = 1'b0; m_idx = '0; m_edge = 0;
  endtask

  // A digit is captured once a legal (anode, segment) pair has been observed
  // unchanged for SETTLE consecutive synchronized samples.
  task automatic model_edge(input logic [3:0] an, input logic [6:0] seg, input logic rn);
    logic [10:0] obs;
    logic        legal;
    int          k;
    logic [3:0]  c;
    if (!rn) begin
      model_reset();
      return;
    end
    obs  = m_d2;
    m_d2 = m_d1;
    m_d1 = {an, seg};
    legal = ($countones(~obs[10:7]) == 1);
    if (!legal) m_run = 0;
    else if (m_run > 0 && obs == m_prev) m_run++;
    else m_run = 1;
    m_prev   = obs;
    m_strobe = 1'b0;
    if ((m_edge % TIMEOUT) == TIMEOUT - 1) begin
      m_valid = m_valid & m_seen;
      m_seen  = '0;
    end
    if (legal && m_run == SETTLE) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (!obs[7+i]) k = i;
      c = ref_code(obs[6:0]);
      m_bcd[4*k +: 4] = c;
      m_valid[k] = 1'b1;
      m_seen[k]  = 1'b1;
      m_blank[k] = (c == 4'hF);
      m_err[k]   = (c == 4'hE);
      m_strobe   = 1'b1;
      m_idx      = 2'(k);
    end
    m_edge++;
  endtask

  task automatic tick(input logic [3:0] an, input logic [6:0] seg, input logic rn);
    an_in  = an;
    seg_in = seg;
    rst_n  = rn;
    @(posedge clk);
    model_edge(an, seg, rn);
    @(negedge clk);
    check_eq("bcd_out", 32'(bcd_out), 32'(m_bcd));
    check_eq("digit_valid", 32'(digit_valid), 32'(m_valid));
    check_eq("digit_blank", 32'(digit_blank), 32'(m_blank));
    check_eq("digit_err", 32'(digit_err), 32'(m_err));
    check_eq("cap_strobe", 32'(cap_strobe), 32'(m_strobe));
    if (m_strobe) check_eq("cap_idx", 32'(cap_idx), 32'(m_idx));
    if (cap_strobe) begin
      strobes++;
      strobe_log.push_back(int'(cap_idx));
    end
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) tick(an, seg, 1'b1);
  endtask

  task automatic clear_log();
    strobes = 0;
    strobe_log.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_at;
    logic [3:0]  d [4];
    logic [15:0] exp_bcd;

    model_reset();
    rst_n = 1'b0; an_in = 4'hF; seg_in = 7'h7F;
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick(4'hF, 7'h7F, 1'b0);
    check_eq("rst_bcd", 32'(bcd_out), 32'h0);
    check_eq("rst_valid", 32'(digit_valid), 32'h0);
    check_eq("rst_blank_err", 32'({digit_blank, digit_err}), 32'h0);
    check_eq("rst_strobe_idx", 32'({cap_strobe, cap_idx}), 32'h0);

    // Single digit: first capture latency and no recapture while held.
    clear_log();
    first_at = -1;
    for (int i = 1; i <= 14; i++) begin
      tick(4'b1110, 7'b0110000, 1'b1);
      if (cap_strobe && first_at < 0) first_at = i;
    end
    check_eq("first_latency", 32'(first_at), 32'd6);
    check_eq("held_strobes", 32'(strobes), 32'd1);
    check_eq("d0_code", 32'(bcd_out[3:0]), 32'h3);
    check_eq("d0_valid", 32'(digit_valid), 32'b0001);

    // Scan 3,2,1,0 with 9,8,7,5.
    clear_log();
    for (int j = 0; j < 4; j++) begin
      int vals [4] = '{9, 8, 7, 5};
      hold(an_sel(3 - j), PAT[vals[j]], 10);
      hold(4'hF, 7'h7F, 2);
    end
    check_eq("scan_bcd", 32'(bcd_out), 32'h9875);
    check_eq("scan_valid", 32'(digit_valid), 32'hF);
    check_eq("scan_strobes", 32'(strobes), 32'd4);
    for (int j = 0; j < strobe_log.size() && j < 4; j++)
      check_eq("scan_order", 32'(strobe_log[j]), 32'(3 - j));

    // Segments toggling faster than the settle window never capture.
    clear_log();
    for (int i = 0; i < 18; i++) hold(4'b1101, ((i / 3) % 2) ? PAT[1] : PAT[2], 1);
    check_eq("toggle_nocap", 32'(strobes), 32'd0);
    hold(4'b1101, 7'b0011001, 10);
    check_eq("d1_code", 32'(bcd_out[7:4]), 32'h4);
    check_eq("d1_strobes", 32'(strobes), 32'd1);

    // Blank then non-BCD on digit 2.
    hold(4'b1011, 7'b1111111, 10);
    check_eq("d2_blank_code", 32'(bcd_out[11:8]), 32'hF);
    check_eq("d2_blank_flag", 32'({digit_blank[2], digit_err[2]}), 32'b10);
    hold(4'b1011, 7'b0101010, 10);
    check_eq("d2_err_code", 32'(bcd_out[11:8]), 32'hE);
    check_eq("d2_err_flag", 32'({digit_blank[2], digit_err[2]}), 32'b01);

    // Random scanning including illegal anodes and occasional resets.
    for (int n = 0; n < 250; n++) begin
      int mode, len;
      logic [3:0] a;
      logic [6:0] s;
      mode = $urandom_range(0, 9);
      len  = $urandom_range(1, 12);
      s    = ($urandom_range(0, 4) == 0) ? 7'($urandom) : PAT[$urandom_range(0, 9)];
      if (mode <= 5) a = an_sel($urandom_range(0, 3));
      else if (mode <= 7) a = 4'hF;
      else begin
        a = 4'($urandom);
        if ($countones(~a) < 2) a = 4'b0000;
      end
      if (mode == 9) tick(a, s, 1'b0);
      else hold(a, s, len);
    end

    // Capture all four, then let them age out.
    hold(4'hF, 7'h7F, 2);
    for (int k = 0; k < 4; k++) begin
      d[k] = 4'($urandom_range(0, 9));
      hold(an_sel(k), PAT[d[k]], 10);
      hold(4'hF, 7'h7F, 2);
    end
    exp_bcd = {d[3], d[2], d[1], d[0]};
    check_eq("all_bcd", 32'(bcd_out), 32'(exp_bcd));
    check_eq("all_valid", 32'(digit_valid), 32'hF);
    hold(4'hF, 7'h7F, 2 * TIMEOUT + 8);
    check_eq("aged_valid", 32'(digit_valid), 32'h0);
    check_eq("aged_bcd", 32'(bcd_out), 32'(exp_bcd));
    clear_log();
    hold(4'b1100, PAT[5], 12);
    check_eq("illegal_nocap", 32'(strobes), 32'd0);

    // Reset one cycle before a pending capture.
    clear_log();
    hold(4'b0111, PAT[6], 4);
    tick(4'hF, 7'h7F, 1'b0);
    hold(4'hF, 7'h7F, 10);
    check_eq("rst_pending_strobes", 32'(strobes), 32'd0);
    check_eq("rst_pending_bcd", 32'(bcd_out), 32'h0);
    check_eq("rst_pending_flags", 32'({digit_valid, digit_blank, digit_err}), 32'h0);
    check_eq("rst_pending_idx", 32'({cap_strobe, cap_idx}), 32'h0);
    first_at = -1;
    for (int i = 1; i <= 8; i++) begin
      tick(4'b0111, PAT[6], 1'b1);
      if (cap_strobe && first_at < 0) first_at = i;
    end
    check_eq("post_rst_latency", 32'(first_at), 32'd6);
    check_eq("post_rst_code", 32'(bcd_out[15:12]), 32'h6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
